// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared opcode constants, sequencer state encoding and default
//               widths for the program-counter control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    localparam int DEF_OPW   = 2;
    localparam int DEF_ADDRW = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_JNP = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_decode
// Description : Combinational decode of the latched opcode (plus r2 for JNP)
//               into the PC and register strobes, active only during EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_decode
    import pc_sequencer_pkg::*;
#(
    parameter int OPW   = DEF_OPW,
    parameter int ADDRW = DEF_ADDRW
) (
    input  logic             exec,
    input  logic [OPW-1:0]   opcode,
    input  logic [ADDRW-1:0] operand,
    input  logic             r2,
    output logic             inc,
    output logic             jnp,
    output logic [ADDRW-1:0] jmp_target,
    output logic             acc_we,
    output logic             r2_we
);

    // Strobe decode; the JNP condition is resolved here so inc and jnp stay exclusive
    always_comb begin
        inc        = 1'b0;
        jnp        = 1'b0;
        jmp_target = '0;
        acc_we     = 1'b0;
        r2_we      = 1'b0;
        if (exec) begin
            case (opcode)
                OPW'(OP_ADD): begin
                    acc_we = 1'b1;
                    inc    = 1'b1;
                end
                OPW'(OP_DEC): begin
                    r2_we = 1'b1;
                    inc   = 1'b1;
                end
                OPW'(OP_JNP): begin
                    if (r2) begin
                        inc = 1'b1;
                    end else begin
                        jnp        = 1'b1;
                        jmp_target = operand;
                    end
                end
                default: begin
                    // HLT issues no strobes
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute sequencer for the 2-bit PC datapath. Holds the
//               state register, instruction register, retired-instruction
//               counter and watchdog; strobes come from pc_seq_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int OPW       = DEF_OPW,
    parameter int ADDRW     = DEF_ADDRW,
    parameter int CNT_W     = 8,
    parameter int MAX_INSTR = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [ADDRW-1:0] operand,
    input  logic             r2,
    output logic             ir_load,
    output logic             inc,
    output logic             jnp,
    output logic [ADDRW-1:0] jmp_target,
    output logic             acc_we,
    output logic             r2_we,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] c_max_instr = CNT_W'(MAX_INSTR);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [OPW+ADDRW-1:0]     r_ir;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_timeout;

    logic [OPW-1:0]           w_ir_op;
    logic [ADDRW-1:0]         w_ir_operand;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_exec;
    logic                     w_is_hlt;
    logic                     w_retire;
    logic                     w_watchdog;

    assign w_ir_op      = r_ir[OPW+ADDRW-1:ADDRW];
    assign w_ir_operand = r_ir[ADDRW-1:0];
    assign w_exec       = (r_state == ST_EXEC);
    assign w_is_hlt     = (w_ir_op == OPW'(OP_HLT));
    assign w_retire     = w_exec && !w_is_hlt;
    assign w_cnt_nxt    = r_cnt + CNT_W'(1);
    assign w_watchdog   = (w_cnt_nxt == c_max_instr);

    // State register; reset forces IDLE so every decoded output drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection: HLT or watchdog expiry ends execution for good
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (w_is_hlt || w_watchdog) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default:  w_state_nxt = ST_HALT;
        endcase
    end

    // Instruction register, retired count and watchdog flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir      <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_ir <= {opcode, operand};
            end
            if (w_retire) begin
                r_cnt <= w_cnt_nxt;
                if (w_watchdog) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    pc_seq_decode #(
        .OPW   (OPW),
        .ADDRW (ADDRW)
    ) u_decode (
        .exec       (w_exec),
        .opcode     (w_ir_op),
        .operand    (w_ir_operand),
        .r2         (r2),
        .inc        (inc),
        .jnp        (jnp),
        .jmp_target (jmp_target),
        .acc_we     (acc_we),
        .r2_we      (r2_we)
    );

    assign ir_load   = (r_state == ST_FETCH);
    assign busy      = (r_state == ST_FETCH) || w_exec;
    assign halted    = (r_state == ST_HALT);
    assign timeout   = r_timeout;
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Randomized program runs of pc_sequencer checked against an
//               instruction-level model of the 4-word machine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] opcode;
    logic [1:0] operand;
    logic       r2;

    // instance with default watchdog (255)
    logic       a_il, a_inc, a_jnp, a_acc, a_r2we, a_busy, a_halt, a_to;
    logic [1:0] a_tgt;
    logic [7:0] a_cnt;
    // instance with short watchdog (4)
    logic       b_il, b_inc, b_jnp, b_acc, b_r2we, b_busy, b_halt, b_to;
    logic [1:0] b_tgt;
    logic [7:0] b_cnt;

    int total = 0;
    int bad   = 0;

    logic [3:0] prog [4];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .operand(operand), .r2(r2),
        .ir_load(a_il), .inc(a_inc), .jnp(a_jnp), .jmp_target(a_tgt), .acc_we(a_acc),
        .r2_we(a_r2we), .busy(a_busy), .halted(a_halt), .timeout(a_to), .instr_cnt(a_cnt)
    );

    pc_sequencer #(.MAX_INSTR(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .operand(operand), .r2(r2),
        .ir_load(b_il), .inc(b_inc), .jnp(b_jnp), .jmp_target(b_tgt), .acc_we(b_acc),
        .r2_we(b_r2we), .busy(b_busy), .halted(b_halt), .timeout(b_to), .instr_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ir_load, inc, jnp, jmp_target[1:0], acc_we, r2_we, busy, halted, timeout}
    function automatic logic [10:0] obs(input int sel);
        if (sel == 0) return {a_il, a_inc, a_jnp, a_tgt, a_acc, a_r2we, a_busy, a_halt, a_to};
        return {b_il, b_inc, b_jnp, b_tgt, b_acc, b_r2we, b_busy, b_halt, b_to};
    endfunction

    function automatic logic [7:0] obs_cnt(input int sel);
        return (sel == 0) ? a_cnt : b_cnt;
    endfunction

    function automatic logic [10:0] ex(input logic il, input logic inc, input logic jnp,
                                       input logic [1:0] tgt, input logic acc, input logic r2we,
                                       input logic busy, input logic halt, input logic to);
        return {il, inc, jnp, tgt, acc, r2we, busy, halt, to};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; opcode = 2'b00; operand = 2'b00; r2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Executes the program in prog[] on instance sel, modelling it one instruction at a time
    task automatic run_prog(input int sel, input int maxi, input string name);
        int         pc   = 0;
        int         cnt  = 0;
        bit         done = 0;
        bit         to   = 0;
        logic [3:0] ir;
        logic [10:0] e;
        @(negedge clk);
        start = 1'b1; r2 = 1'($urandom); #1;
        chk({name, "/idle"}, 32'(obs(sel)), 32'(ex(0,0,0,2'b00,0,0,0,0,0)));
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            start = 1'($urandom); ir = prog[pc]; {opcode, operand} = ir; r2 = 1'($urandom); #1;
            chk({name, "/fetch"}, 32'(obs(sel)), 32'(ex(1,0,0,2'b00,0,0,1,0,0)));
            chk({name, "/cnt"}, 32'(obs_cnt(sel)), 32'(cnt));
            @(negedge clk);
            {opcode, operand} = 4'($urandom); r2 = 1'($urandom); #1;
            case (ir[3:2])
                2'b00:   e = ex(0,1,0,2'b00,1,0,1,0,0);
                2'b01:   e = ex(0,1,0,2'b00,0,1,1,0,0);
                2'b10:   e = r2 ? ex(0,1,0,2'b00,0,0,1,0,0) : ex(0,0,1,ir[1:0],0,0,1,0,0);
                default: e = ex(0,0,0,2'b00,0,0,1,0,0);
            endcase
            chk({name, "/exec"}, 32'(obs(sel)), 32'(e));
            if (ir[3:2] == 2'b11) begin
                done = 1;
            end else begin
                cnt++;
                pc = (ir[3:2] == 2'b10 && !r2) ? int'(ir[1:0]) : (pc + 1) % 4;
                if (cnt == maxi) begin
                    done = 1;
                    to   = 1;
                end
            end
        end
        repeat (5) begin
            @(negedge clk);
            start = 1'b1; {opcode, operand} = 4'($urandom); r2 = 1'($urandom); #1;
            chk({name, "/halt"}, 32'(obs(sel)), 32'(ex(0,0,0,2'b00,0,0,0,1,to)));
            chk({name, "/halt_cnt"}, 32'(obs_cnt(sel)), 32'(cnt));
        end
        start = 1'b0;
    endtask

    initial begin
        // idle after reset, start held low
        do_reset();
        repeat (10) begin
            @(negedge clk);
            {opcode, operand} = 4'($urandom); r2 = 1'($urandom); #1;
            chk("idle_a", 32'(obs(0)), 32'(0));
            chk("idle_b", 32'(obs(1)), 32'(0));
            chk("idle_cnt", 32'(a_cnt), 32'(0));
        end

        // straight-line ADDs run to the 255 watchdog
        for (int i = 0; i < 4; i++) prog[i] = {2'b00, 2'($urandom)};
        run_prog(0, 255, "add255");

        // JNP to word 3 with random flag
        do_reset();
        for (int i = 0; i < 4; i++) prog[i] = 4'b1011;
        run_prog(0, 255, "jnp");

        // immediate HLT
        do_reset();
        prog[0] = 4'b1100; prog[1] = 4'b0000; prog[2] = 4'b0000; prog[3] = 4'b0000;
        run_prog(0, 255, "hlt");

        // short watchdog, all ADD
        do_reset();
        for (int i = 0; i < 4; i++) prog[i] = 4'b0000;
        run_prog(1, 4, "wd4");

        // async reset during the second ADD execute
        do_reset();
        @(negedge clk); start = 1'b1; {opcode, operand} = 4'b0000; #1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); start = 1'b0; #1;
            chk("mr_fetch", 32'(obs(0)), 32'(ex(1,0,0,2'b00,0,0,1,0,0)));
            @(negedge clk); #1;
            chk("mr_exec", 32'(obs(0)), 32'(ex(0,1,0,2'b00,1,0,1,0,0)));
        end
        rst = 1'b1; #1;
        chk("mr_async", 32'(obs(0)), 32'(0));
        chk("mr_cnt", 32'(a_cnt), 32'(0));
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("mr_idle", 32'(obs(0)), 32'(0));
            chk("mr_idle_cnt", 32'(a_cnt), 32'(0));
        end
        for (int i = 0; i < 4; i++) prog[i] = {2'($urandom_range(0, 2)), 2'($urandom)};
        run_prog(0, 255, "mr_run");

        // random programs on both watchdog settings
        for (int t = 0; t < 20; t++) begin
            int sel;
            do_reset();
            for (int i = 0; i < 4; i++) prog[i] = 4'($urandom);
            sel = int'($urandom_range(0, 1));
            run_prog(sel, (sel == 0) ? 255 : 4, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
